// File: rtl/conv_pool_out.sv
// Max-pools POOL consecutive conv results per frame, optional ReLU, saturates to OUT_WIDTH.
// Latency: result registered 1 cycle after the group-completing input transfer.
// Backpressure: s_ready drops only when a completing sample meets a stalled, unsent result.
module conv_pool_out #(
  parameter int IN_WIDTH  = 21,
  parameter int OUT_WIDTH = 16,
  parameter int POOL      = 2,
  parameter int FRAME_LEN = 97,
  parameter int RELU      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data_in,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data_out,
  output logic                 m_last
);

  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int GW = $clog2(POOL);
  localparam logic [FW-1:0] FRAME_END = FW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GRP_END   = GW'(POOL - 1);
  // Output range limits expressed at the input width so saturation is the only narrowing.
  localparam logic signed [IN_WIDTH-1:0] SAT_HI =
      {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] SAT_LO =
      {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {GRP_EMPTY, GRP_ACCUM} grp_state_t;

  grp_state_t                  grp_state;
  logic [GW-1:0]               grp_cnt;
  logic [FW-1:0]               frame_cnt;
  logic signed [IN_WIDTH-1:0]  run_max;

  logic signed [IN_WIDTH-1:0]  sample;
  logic signed [IN_WIDTH-1:0]  grp_max;
  logic signed [IN_WIDTH-1:0]  relu_val;
  logic [OUT_WIDTH-1:0]        sat_val;
  logic                        frame_end;
  logic                        completing;
  logic                        in_xfer;

  assign sample     = $signed(s_data_in);
  assign frame_end  = (frame_cnt == FRAME_END);
  // A short final group closes at the frame boundary without padding.
  assign completing = (grp_cnt == GRP_END) || frame_end;
  // Only a completing sample needs the output register free (or freeing this cycle).
  assign s_ready    = !(completing && m_valid && !m_ready);
  assign in_xfer    = s_valid && s_ready;

  // Running max including the current sample, then ReLU and saturation of that value.
  always_comb begin
    grp_max = sample;
    if (grp_state == GRP_ACCUM && run_max > sample) grp_max = run_max;
    relu_val = grp_max;
    if (RELU != 0 && grp_max[IN_WIDTH-1]) relu_val = '0;
    if (relu_val > SAT_HI)      sat_val = SAT_HI[OUT_WIDTH-1:0];
    else if (relu_val < SAT_LO) sat_val = SAT_LO[OUT_WIDTH-1:0];
    else                        sat_val = relu_val[OUT_WIDTH-1:0];
  end

  // Frame/group counters and the EMPTY/ACCUM group state advance on each accepted sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grp_state <= GRP_EMPTY;
      grp_cnt   <= '0;
      frame_cnt <= '0;
      run_max   <= '0;
    end else if (in_xfer) begin
      frame_cnt <= frame_end ? '0 : frame_cnt + FW'(1);
      run_max   <= grp_max;
      if (completing) begin
        grp_cnt   <= '0;
        grp_state <= GRP_EMPTY;
      end else begin
        grp_cnt   <= grp_cnt + GW'(1);
        grp_state <= GRP_ACCUM;
      end
    end
  end

  // Output register: a new completion wins over draining, giving bubble-free throughput.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_data_out <= '0;
    end else if (in_xfer && completing) begin
      m_valid    <= 1'b1;
      m_last     <= frame_end;
      m_data_out <= sat_val;
    end else if (m_valid && m_ready) begin
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_pool_out.sv
module tb_conv_pool_out;
  localparam int IW = 21;
  localparam int OW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // main instance (defaults)
  logic s_valid, s_ready, m_valid, m_ready, m_last;
  logic [IW-1:0] s_data_in;
  logic [OW-1:0] m_data_out;
  // saturation instance (RELU=0, FRAME_LEN=2)
  logic sa_s_valid, sa_s_ready, sa_m_valid, sa_m_ready, sa_m_last;
  logic [IW-1:0] sa_s_data;
  logic [OW-1:0] sa_m_data;
  // relu instance (RELU=1, FRAME_LEN=2)
  logic ra_s_valid, ra_s_ready, ra_m_valid, ra_m_ready, ra_m_last;
  logic [IW-1:0] ra_s_data;
  logic [OW-1:0] ra_m_data;

  conv_pool_out dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data_in(s_data_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data_out(m_data_out), .m_last(m_last));

  conv_pool_out #(.FRAME_LEN(2), .RELU(0)) dut_sat (
    .clk(clk), .reset(reset), .s_valid(sa_s_valid), .s_ready(sa_s_ready), .s_data_in(sa_s_data),
    .m_valid(sa_m_valid), .m_ready(sa_m_ready), .m_data_out(sa_m_data), .m_last(sa_m_last));

  conv_pool_out #(.FRAME_LEN(2), .RELU(1)) dut_relu (
    .clk(clk), .reset(reset), .s_valid(ra_s_valid), .s_ready(ra_s_ready), .s_data_in(ra_s_data),
    .m_valid(ra_m_valid), .m_ready(ra_m_ready), .m_data_out(ra_m_data), .m_last(ra_m_last));

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic          last;
    logic [OW-1:0] data;
  } res_t;

  res_t          exp_q[$];
  logic [OW-1:0] small_q[$];
  int            last_pos[$];
  int            n_res, n_last;

  // reference model state for the main instance
  int     md_fc = 0;
  int     md_gc = 0;
  longint md_max = 0;

  function automatic logic [OW-1:0] sat_out(input longint v, input bit relu);
    longint r;
    r = v;
    if (relu && r < 0) r = 0;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[OW-1:0];
  endfunction

  function automatic bit model_completing();
    return (md_gc == 1) || (md_fc == 96);
  endfunction

  task automatic model_accept(input logic [IW-1:0] d);
    longint v;
    v = longint'($signed(d));
    if (md_gc == 0 || v > md_max) md_max = v;
    if (model_completing()) begin
      exp_q.push_back(res_t'{last: (md_fc == 96), data: sat_out(md_max, 1'b1)});
      md_gc = 0;
    end else begin
      md_gc++;
    end
    md_fc = (md_fc == 96) ? 0 : md_fc + 1;
  endtask

  // drive one sample into the main instance; returns at posedge+1 after acceptance
  task automatic send(input logic [IW-1:0] d);
    bit rdy;
    int tries;
    tries = 0;
    rdy = 1'b0;
    s_valid = 1'b1;
    s_data_in = d;
    forever begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      tries++;
      if (tries > 200) begin
        checks++;
        $display("FAIL send_timeout: sample %0d not accepted within 200 cycles", $signed(d));
        break;
      end
    end
    if (rdy) model_accept(d);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !m_valid) break;
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    else passed++;
  endtask

  task automatic clear_counts();
    n_res = 0;
    n_last = 0;
    last_pos.delete();
  endtask

  // scoreboard monitor: an output transfer happens at the next rising edge
  always @(negedge clk) begin : mon
    res_t e;
    if (reset && m_valid && m_ready) begin
      checks++;
      n_res++;
      if (m_last) begin
        n_last++;
        last_pos.push_back(n_res);
      end
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_result: got data=%0d last=%0b, no result expected",
                 $signed(m_data_out), m_last);
      end else begin
        e = exp_q.pop_front();
        if ({m_last, m_data_out} !== e)
          $display("FAIL result_%0d: got data=%0d last=%0b, required data=%0d last=%0b",
                   n_res, $signed(m_data_out), m_last, $signed(e.data), e.last);
        else passed++;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    s_valid = 1'b0; s_data_in = '0; m_ready = 1'b1;
    sa_s_valid = 1'b0; sa_s_data = '0; sa_m_ready = 1'b1;
    ra_s_valid = 1'b0; ra_s_data = '0; ra_m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b required 0", m_valid); else passed++;
    checks++; if (m_last !== 1'b0) $display("FAIL reset_m_last: got %b required 0", m_last); else passed++;
    checks++; if (m_data_out !== '0) $display("FAIL reset_m_data: got %h required 0", m_data_out); else passed++;
    checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b required 1", s_ready); else passed++;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ramp();
    bit exp_v;
    clear_counts();
    m_ready = 1'b1;
    for (int k = 0; k < 97; k++) begin
      send(IW'(k - 48));
      exp_v = (k % 2 == 1) || (k == 96);
      checks++;
      if (m_valid !== exp_v) $display("FAIL ramp_latency_k%0d: m_valid=%b required %b", k, m_valid, exp_v);
      else passed++;
    end
    drain();
    checks++; if (n_res !== 49) $display("FAIL ramp_count: got %0d required 49", n_res); else passed++;
    checks++; if (n_last !== 1) $display("FAIL ramp_last_count: got %0d required 1", n_last); else passed++;
    checks++; if (last_pos[0] !== 49) $display("FAIL ramp_last_pos: got %0d required 49", last_pos[0]); else passed++;
  endtask

  task automatic test_backpressure();
    clear_counts();
    fork
      begin
        for (int k = 0; k < 97; k++) send(IW'($urandom));
      end
      begin
        bit held;
        logic [OW-1:0] held_dat;
        bit exp_rdy;
        held = 1'b0;
        held_dat = '0;
        m_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          exp_rdy = !(model_completing() && m_valid);
          checks++;
          if (s_ready !== exp_rdy) $display("FAIL bp_s_ready_c%0d: got %b required %b", c, s_ready, exp_rdy);
          else passed++;
          if (m_valid) begin
            if (!held) begin
              held = 1'b1;
              held_dat = m_data_out;
            end else begin
              checks++;
              if (m_data_out !== held_dat)
                $display("FAIL bp_stable_c%0d: got %h required %h", c, m_data_out, held_dat);
              else passed++;
            end
          end
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
    join
    drain();
    checks++; if (n_res !== 49) $display("FAIL bp_count: got %0d required 49", n_res); else passed++;
    checks++; if (n_last !== 1) $display("FAIL bp_last_count: got %0d required 1", n_last); else passed++;
  endtask

  task automatic test_random();
    bit snd_done;
    snd_done = 1'b0;
    clear_counts();
    fork
      begin
        for (int k = 0; k < 291; k++) begin
          while ($urandom_range(0, 1) == 0) begin
            @(posedge clk);
            #1;
          end
          send(IW'($urandom));
        end
        snd_done = 1'b1;
      end
      begin
        while (!snd_done) begin
          m_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    m_ready = 1'b1;
    drain();
    checks++; if (n_res !== 147) $display("FAIL rand_count: got %0d required 147", n_res); else passed++;
    checks++; if (n_last !== 3) $display("FAIL rand_last_count: got %0d required 3", n_last); else passed++;
    checks++; if (last_pos[0] !== 49) $display("FAIL rand_last0: got %0d required 49", last_pos[0]); else passed++;
    checks++; if (last_pos[1] !== 98) $display("FAIL rand_last1: got %0d required 98", last_pos[1]); else passed++;
    checks++; if (last_pos[2] !== 147) $display("FAIL rand_last2: got %0d required 147", last_pos[2]); else passed++;
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    for (int k = 0; k < 39; k++) send(IW'($urandom));
    m_ready = 1'b0;
    send(IW'(1000));
    send(IW'(2000));
    checks++; if (m_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b required 1", m_valid); else passed++;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b required 0", m_valid); else passed++;
    checks++; if (m_data_out !== '0) $display("FAIL mid_rst_data: got %h required 0", m_data_out); else passed++;
    checks++; if (m_last !== 1'b0) $display("FAIL mid_rst_last: got %b required 0", m_last); else passed++;
    checks++; if (s_ready !== 1'b1) $display("FAIL mid_rst_s_ready: got %b required 1", s_ready); else passed++;
    exp_q.delete();
    md_fc = 0;
    md_gc = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_ready = 1'b1;
    clear_counts();
    for (int k = 0; k < 97; k++) send(IW'($urandom));
    drain();
    checks++; if (n_res !== 49) $display("FAIL mid_count: got %0d required 49", n_res); else passed++;
    checks++; if (n_last !== 1) $display("FAIL mid_last_count: got %0d required 1", n_last); else passed++;
  endtask

  // one pair into a FRAME_LEN=2 instance (sel=0 saturation, sel=1 relu)
  task automatic small_pair(input bit sel, input int a, input int b, input logic [OW-1:0] exp_d);
    bit found;
    logic [OW-1:0] e;
    found = 1'b0;
    small_q.push_back(exp_d);
    for (int i = 0; i < 2; i++) begin
      if (sel) begin ra_s_valid = 1'b1; ra_s_data = IW'((i == 0) ? a : b); end
      else begin sa_s_valid = 1'b1; sa_s_data = IW'((i == 0) ? a : b); end
      @(posedge clk);
      #1;
    end
    sa_s_valid = 1'b0;
    ra_s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sel ? ra_m_valid : sa_m_valid) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      $display("FAIL pair_timeout_sel%0d: no result for (%0d,%0d)", sel, a, b);
      void'(small_q.pop_front());
    end else begin
      e = small_q.pop_front();
      if ((sel ? ra_m_data : sa_m_data) !== e)
        $display("FAIL pair_sel%0d (%0d,%0d): got %0d required %0d", sel, a, b,
                 $signed(sel ? ra_m_data : sa_m_data), $signed(e));
      else passed++;
      checks++;
      if ((sel ? ra_m_last : sa_m_last) !== 1'b1)
        $display("FAIL pair_last_sel%0d: got 0 required 1", sel);
      else passed++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    small_pair(1'b0, 1048575, 5, 16'sd32767);
    small_pair(1'b0, -1048576, -70000, -16'sd32768);
    small_pair(1'b0, -3, -9, -16'sd3);
  endtask

  task automatic test_relu();
    small_pair(1'b1, -1048576, -1, 16'sd0);
    small_pair(1'b1, 300, -2, 16'sd300);
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_ramp();
    test_saturation();
    test_relu();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
